parallel_2_serial_spi: RTL and testbench

//   SPI transmit serializer: the companion to serial_2_parallel. Takes a 16-bit

---
 rtl/parallel_2_serial_spi.sv | 171 +++++++++++++++++
 tb/tb_parallel_2_serial_spi.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/parallel_2_serial_spi.sv
// SPI mode-0 transmit serializer: accepts one word over valid/ready and drives
// a single CS-framed burst of WORD_W SCK pulses, MSB first, from the system clock.
module parallel_2_serial_spi #(
  parameter int WORD_W    = 16,
  parameter int CLK_DIV   = 5,
  parameter int CS_SETUP  = 2,
  parameter int CS_HOLD   = 2,
  parameter int CS_IDLE   = 2,
  parameter int BYTE_SWAP = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_done,
  output logic              busy,
  output logic              spi_cs,
  output logic              spi_sck,
  output logic              spi_mosi
);

  localparam int MAX_A   = (CS_SETUP > CLK_DIV) ? CS_SETUP : CLK_DIV;
  localparam int MAX_B   = (CS_HOLD > CS_IDLE) ? CS_HOLD : CS_IDLE;
  localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int BIT_W   = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);
  localparam logic [CNT_W-1:0] IDLE_LAST  = CNT_W'((CS_IDLE > 0) ? CS_IDLE - 1 : 0);
  localparam logic [BIT_W-1:0] BIT_ZERO   = BIT_W'(0);
  localparam logic [BIT_W-1:0] BIT_ONE    = BIT_W'(1);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(WORD_W - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  // Reverses byte order so the far-end receiver's own swap restores the word.
  function automatic logic [WORD_W-1:0] swap_bytes(input logic [WORD_W-1:0] w);
    logic [WORD_W-1:0] r;
    r = w;
    for (int i = 0; i < WORD_W / 8; i++) begin
      r[i*8 +: 8] = w[(WORD_W/8 - 1 - i)*8 +: 8];
    end
    return r;
  endfunction

  state_t            state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [BIT_W-1:0]  bit_cnt_r;
  logic [WORD_W-1:0] shreg_r;
  logic              cs_r;
  logic              sck_r;
  logic              mosi_r;
  logic              done_r;
  logic [WORD_W-1:0] load_word_s;

  // Selects the word image that gets loaded into the shift register.
  always_comb begin
    load_word_s = tx_data;
    if (BYTE_SWAP != 0) begin
      load_word_s = swap_bytes(tx_data);
    end else begin
      load_word_s = tx_data;
    end
  end

  // Frame sequencer; every SPI pin and the done pulse come straight from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      cnt_r     <= CNT_ZERO;
      bit_cnt_r <= BIT_ZERO;
      shreg_r   <= '0;
      cs_r      <= 1'b1;
      sck_r     <= 1'b0;
      mosi_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          cnt_r     <= CNT_ZERO;
          bit_cnt_r <= BIT_ZERO;
          if (tx_valid) begin
            shreg_r <= load_word_s;
            mosi_r  <= load_word_s[WORD_W-1];
            cs_r    <= 1'b0;
            sck_r   <= 1'b0;
            state_r <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (cnt_r == SETUP_LAST) begin
            cnt_r   <= CNT_ZERO;
            state_r <= ST_SHIFT;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_SHIFT: begin
          if (cnt_r == DIV_LAST) begin
            cnt_r <= CNT_ZERO;
            if (!sck_r) begin
              sck_r <= 1'b1;
            end else begin
              sck_r <= 1'b0;
              // The final falling edge leaves the last bit parked on mosi.
              if (bit_cnt_r == BIT_LAST) begin
                state_r <= ST_HOLD;
              end else begin
                bit_cnt_r <= bit_cnt_r + BIT_ONE;
                shreg_r   <= {shreg_r[WORD_W-2:0], 1'b0};
                mosi_r    <= shreg_r[WORD_W-2];
              end
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_HOLD: begin
          if (cnt_r == HOLD_LAST) begin
            cnt_r  <= CNT_ZERO;
            cs_r   <= 1'b1;
            mosi_r <= 1'b0;
            done_r <= 1'b1;
            if (CS_IDLE == 0) begin
              state_r <= ST_IDLE;
            end else begin
              state_r <= ST_GAP;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_GAP: begin
          if (cnt_r == IDLE_LAST) begin
            cnt_r   <= CNT_ZERO;
            state_r <= ST_IDLE;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= CNT_ZERO;
          cs_r    <= 1'b1;
          sck_r   <= 1'b0;
          mosi_r  <= 1'b0;
        end
      endcase
    end
  end

  assign tx_ready = (state_r == ST_IDLE);
  assign busy     = (state_r != ST_IDLE);
  assign tx_done  = done_r;
  assign spi_cs   = cs_r;
  assign spi_sck  = sck_r;
  assign spi_mosi = mosi_r;

endmodule

// File: tb/tb_parallel_2_serial_spi.sv
// Bench for parallel_2_serial_spi: a byte-swapping and a straight instance share
// clock and reset; a wire monitor scores each frame against queued expectations.
module tb_parallel_2_serial_spi;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] tx_data  [2];
  logic        tx_valid [2];
  logic        tx_ready [2];
  logic        tx_done  [2];
  logic        busy     [2];
  logic        cs       [2];
  logic        sck      [2];
  logic        mosi     [2];

  int checks = 0;
  int errors = 0;

  logic [15:0] q0 [$];
  logic [15:0] q1 [$];
  int          bits     [2];
  int          low_cnt  [2];
  int          hi_cnt   [2];
  int          done_cnt [2];
  logic [15:0] cap      [2];
  logic        prev_cs  [2];
  logic        prev_sck [2];
  logic        prev_mosi[2];
  logic        seen_rise[2];
  logic        unstable [2];
  logic        ready_bad[2];

  always #5 clk = ~clk;

  parallel_2_serial_spi #(.BYTE_SWAP(1)) u_swap (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
    .tx_ready(tx_ready[0]), .tx_done(tx_done[0]), .busy(busy[0]),
    .spi_cs(cs[0]), .spi_sck(sck[0]), .spi_mosi(mosi[0]));

  parallel_2_serial_spi #(.BYTE_SWAP(0)) u_raw (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
    .tx_ready(tx_ready[1]), .tx_done(tx_done[1]), .busy(busy[1]),
    .spi_cs(cs[1]), .spi_sck(sck[1]), .spi_mosi(mosi[1]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] swap16(input logic [15:0] w);
    return {w[7:0], w[15:8]};
  endfunction

  // Wire monitor: queues expectations on accept and scores each frame at CS rise.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        prev_cs[i] = 1'b1; prev_sck[i] = 1'b0; prev_mosi[i] = 1'b0;
        bits[i] = 0; seen_rise[i] = 1'b0; unstable[i] = 1'b0; ready_bad[i] = 1'b0;
        if (i == 0) q0.delete(); else q1.delete();
      end else begin
        if (tx_valid[i] && tx_ready[i]) begin
          if (i == 0) q0.push_back(swap16(tx_data[0])); else q1.push_back(tx_data[1]);
        end
        if (tx_done[i]) done_cnt[i]++;
        if (prev_cs[i] && !cs[i]) begin
          if (seen_rise[i]) check("cs_gap_min", 32'(hi_cnt[i] >= 2), 32'd1);
          low_cnt[i] = 1; bits[i] = 0; cap[i] = 16'h0000;
          unstable[i] = 1'b0; ready_bad[i] = 1'b0;
        end else if (!cs[i]) begin
          low_cnt[i]++;
        end
        if (!cs[i] && (tx_ready[i] || !busy[i])) ready_bad[i] = 1'b1;
        if (!cs[i] && !prev_sck[i] && sck[i]) begin
          cap[i] = {cap[i][14:0], mosi[i]};
          bits[i]++;
        end
        if (prev_sck[i] && sck[i] && (mosi[i] != prev_mosi[i])) unstable[i] = 1'b1;
        if (!prev_cs[i] && cs[i]) begin
          logic [15:0] e;
          check("sck_rises", 32'(bits[i]), 32'd16);
          check("cs_low_cycles", 32'(low_cnt[i]), 32'd164);
          check("done_at_cs_rise", 32'(tx_done[i]), 32'd1);
          check("mosi_idle", 32'(mosi[i]), 32'd0);
          check("mosi_stable_hi", 32'(unstable[i]), 32'd0);
          check("ready_low_in_frame", 32'(ready_bad[i]), 32'd0);
          if (i == 0) begin
            check("q_nonempty", 32'(q0.size() != 0), 32'd1);
            if (q0.size() != 0) begin e = q0.pop_front(); check("wire_word_swap", 32'(cap[i]), 32'(e)); end
          end else begin
            check("q_nonempty", 32'(q1.size() != 0), 32'd1);
            if (q1.size() != 0) begin e = q1.pop_front(); check("wire_word_raw", 32'(cap[i]), 32'(e)); end
          end
          seen_rise[i] = 1'b1;
          hi_cnt[i] = 1;
        end else if (cs[i]) begin
          hi_cnt[i]++;
        end
        prev_cs[i] = cs[i]; prev_sck[i] = sck[i]; prev_mosi[i] = mosi[i];
      end
    end
  end

  task automatic wait_accept(input int i);
    logic ok;
    ok = 1'b0;
    for (int n = 0; n < 2000 && !ok; n++) begin
      @(negedge clk); #1;
      if (tx_ready[i]) ok = 1'b1;
    end
    check("accept_timeout", 32'(ok), 32'd1);
  endtask

  task automatic wait_idle(input int i);
    logic ok;
    ok = 1'b0;
    for (int n = 0; n < 2000 && !ok; n++) begin
      @(negedge clk); #1;
      if (!busy[i] && cs[i]) ok = 1'b1;
    end
    check("idle_timeout", 32'(ok), 32'd1);
  endtask

  task automatic send(input int i, input logic [15:0] w);
    @(posedge clk); #1;
    tx_data[i]  = w;
    tx_valid[i] = 1'b1;
    wait_accept(i);
    @(posedge clk); #1;
    tx_valid[i] = 1'b0;
  endtask

  initial begin
    int d0;
    logic ok;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tx_data[i] = 16'h0000; tx_valid[i] = 1'b0; done_cnt[i] = 0; hi_cnt[i] = 0; low_cnt[i] = 0;
    end
    repeat (3) @(negedge clk);
    #1;
    check("rst_cs", 32'(cs[0]), 32'd1);
    check("rst_sck", 32'(sck[0]), 32'd0);
    check("rst_mosi", 32'(mosi[0]), 32'd0);
    check("rst_ready", 32'(tx_ready[0]), 32'd1);
    check("rst_done", 32'(tx_done[0]), 32'd0);
    check("rst_busy", 32'(busy[0]), 32'd0);
    check("rst_ready_raw", 32'(tx_ready[1]), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    d0 = done_cnt[0];
    send(0, 16'h1234);
    wait_idle(0);
    check("t2_done_pulses", 32'(done_cnt[0] - d0), 32'd1);

    d0 = done_cnt[1];
    send(1, 16'hA5C3);
    wait_idle(1);
    check("t3_done_pulses", 32'(done_cnt[1] - d0), 32'd1);

    d0 = done_cnt[0];
    @(posedge clk); #1;
    tx_data[0] = 16'hFFFF; tx_valid[0] = 1'b1;
    wait_accept(0);
    @(posedge clk); #1;
    tx_data[0] = 16'h0000;
    wait_accept(0);
    @(posedge clk); #1;
    tx_valid[0] = 1'b0;
    wait_idle(0);
    check("t4_done_pulses", 32'(done_cnt[0] - d0), 32'd2);

    d0 = done_cnt[0];
    send(0, 16'h00FF);
    repeat (40) @(posedge clk);
    #1;
    tx_data[0] = 16'hBEEF; tx_valid[0] = 1'b1;
    repeat (30) @(negedge clk);
    #1;
    check("t5_ready_mid", 32'(tx_ready[0]), 32'd0);
    check("t5_busy_mid", 32'(busy[0]), 32'd1);
    @(posedge clk); #1;
    tx_valid[0] = 1'b0;
    wait_idle(0);
    check("t5_done_pulses", 32'(done_cnt[0] - d0), 32'd1);

    d0 = done_cnt[0];
    @(posedge clk); #1;
    tx_data[0] = 16'h5A5A; tx_valid[0] = 1'b1;
    wait_accept(0);
    @(posedge clk); #1;
    tx_valid[0] = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < 2000 && !ok; n++) begin
      @(negedge clk); #2;
      if (bits[0] >= 5) ok = 1'b1;
    end
    check("t6_fifth_rise", 32'(ok), 32'd1);
    check("t6_sck_high", 32'(sck[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_async_cs", 32'(cs[0]), 32'd1);
    check("t6_async_sck", 32'(sck[0]), 32'd0);
    check("t6_async_mosi", 32'(mosi[0]), 32'd0);
    check("t6_async_busy", 32'(busy[0]), 32'd0);
    repeat (3) @(negedge clk);
    check("t6_no_done", 32'(done_cnt[0] - d0), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(0, 16'h8001);
    wait_idle(0);
    check("t6_done_pulses", 32'(done_cnt[0] - d0), 32'd1);

    repeat (10) @(negedge clk);
    check("q0_drained", 32'(q0.size()), 32'd0);
    check("q1_drained", 32'(q1.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
